// File: rtl/obstacle_collision_scanner.sv
// Sequential obstacle scanner: checks one slot per clock against the player hit window.
// Optional macro COLLIDE_Y_WINDOW_EN widens the y test from exact match to +/- Y_MARGIN.
module obstacle_collision_scanner #(
    parameter int NUM_OBJ  = 73,
    parameter int COORD_W  = 11,
    parameter int X_MARGIN = 9,
    parameter int Y_MARGIN = 4,
    localparam int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       update_screen,
    input  logic                       clear_hit,
    input  logic [COORD_W-1:0]         move_step,
    input  logic [COORD_W-1:0]         player_x,
    input  logic [COORD_W-1:0]         player_y,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x_flat,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y_flat,
    input  logic [NUM_OBJ-1:0]         obj_valid,
    output logic                       busy,
    output logic                       scan_done,
    output logic                       is_spike_hit,
    output logic [IDX_W-1:0]           hit_index,
    output logic [COORD_W-1:0]         scroll_offset
);
    // state | meaning
    // IDLE  | waiting for update_screen
    // SCAN  | evaluating slot idx this cycle
    // DONE  | one-cycle completion pulse, scroll update on a clean scan
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MARGIN);
`ifdef COLLIDE_Y_WINDOW_EN
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MARGIN);
`else
    // zero-width window degenerates to exact equality
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MARGIN * 0);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [COORD_W-1:0]  px, py, step;
    logic [COORD_W-1:0]  obj_x [NUM_OBJ];
    logic [COORD_W-1:0]  obj_y [NUM_OBJ];
    logic [COORD_W-1:0]  rel_x;
    logic                scan_hit;
    logic                start;

    for (genvar j = 0; j < NUM_OBJ; j++) begin : g_unpack
        assign obj_x[j] = obj_x_flat[j*COORD_W +: COORD_W];
        assign obj_y[j] = obj_y_flat[j*COORD_W +: COORD_W];
    end

    // Window [c-m, c+m] clamped to the coordinate range on both ends.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] c,
                                       input logic [COORD_W-1:0] m);
        logic [COORD_W-1:0] lo, hi;
        logic [COORD_W:0]   sum;
        lo  = (c < m) ? '0 : c - m;
        sum = {1'b0, c} + {1'b0, m};
        hi  = sum[COORD_W] ? '1 : sum[COORD_W-1:0];
        return (v >= lo) && (v <= hi);
    endfunction

    assign rel_x    = obj_x[idx] - scroll_offset;
    assign scan_hit = (state == SCAN) && obj_valid[idx]
                      && in_window(rel_x, px, XM)
                      && in_window(obj_y[idx], py, YM);
    assign start    = (state == IDLE) && update_screen && !is_spike_hit;
    assign busy      = (state != IDLE);
    assign scan_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (scan_hit || idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            px            <= '0;
            py            <= '0;
            step          <= '0;
            is_spike_hit  <= 1'b0;
            hit_index     <= '0;
            scroll_offset <= '0;
        end else begin
            state <= state_nxt;
            if (clear_hit) begin
                idx           <= '0;
                is_spike_hit  <= 1'b0;
                hit_index     <= '0;
                scroll_offset <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        px   <= player_x;
                        py   <= player_y;
                        step <= move_step;
                        idx  <= '0;
                    end
                    SCAN: if (scan_hit) begin
                        is_spike_hit <= 1'b1;
                        hit_index    <= idx;
                    end else if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                    // a hit is sticky and blocks new scans, so it marks this scan as hit
                    DONE: if (!is_spike_hit) scroll_offset <= scroll_offset + step;
                    default: ;
                endcase
            end
        end
    end
endmodule
